// File: rtl/gene_matcher_stream.sv
// Streaming DNA motif matcher: slides a PAT_LEN-base window over a valid/ready
// base stream and compares it against NUM_PAT patterns with a Hamming tolerance.
module gene_matcher_stream #(
    parameter int PAT_LEN = 8,
    parameter int NUM_PAT = 2,
    parameter int MM_W    = 3,
    parameter int POS_W   = 16,
    parameter int CNT_W   = 12,
    localparam int PW     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    localparam int IW     = $clog2(PAT_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [PW-1:0]            cfg_pat,
    input  logic [IW-1:0]            cfg_idx,
    input  logic [1:0]               cfg_base,
    input  logic [MM_W-1:0]          mm_thresh,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clr_cnt,
    input  logic                     in_valid,
    input  logic [1:0]               in_base,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     match_valid,
    output logic [NUM_PAT-1:0]       match_mask,
    output logic [POS_W-1:0]         match_pos,
    output logic [NUM_PAT*CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SCAN} state_e;

    localparam logic [POS_W-1:0] POS_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IW-1:0]    FILL_LAST = IW'(PAT_LEN - 1);

    state_e                              state_q;
    logic [PAT_LEN-1:0][1:0]             win_q, win_d;
    logic [NUM_PAT-1:0][PAT_LEN-1:0][1:0] pat_q;
    logic [IW-1:0]                       fill_q;
    logic [POS_W-1:0]                    pos_q;
    logic [NUM_PAT-1:0][CNT_W-1:0]       cnt_q;
    logic                                match_valid_q;
    logic [NUM_PAT-1:0]                  match_mask_q;
    logic [POS_W-1:0]                    match_pos_q;

    logic                                accept, cmp;
    logic [NUM_PAT-1:0]                  hit;
    logic [NUM_PAT-1:0][IW:0]            mm;

    assign busy     = (state_q != S_IDLE);
    assign in_ready = busy && !stop;
    assign accept   = in_valid && in_ready;
    assign cmp      = accept && ((state_q == S_SCAN) ||
                                 ((state_q == S_FILL) && (fill_q == FILL_LAST)));

    // Index 0 is the oldest base; the newly accepted base lands at the top.
    assign win_d = {in_base, win_q[PAT_LEN-1:1]};

    always_comb begin
        mm  = '0;
        hit = '0;
        for (int p = 0; p < NUM_PAT; p++) begin
            for (int i = 0; i < PAT_LEN; i++) begin
                if (win_d[i] != pat_q[p][i]) mm[p] = mm[p] + (IW+1)'(1);
            end
            hit[p] = (32'(mm[p]) <= 32'(mm_thresh));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            win_q         <= '0;
            pat_q         <= '0;
            fill_q        <= '0;
            pos_q         <= '0;
            cnt_q         <= '0;
            match_valid_q <= 1'b0;
            match_mask_q  <= '0;
            match_pos_q   <= '0;
        end else begin
            match_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        fill_q  <= '0;
                        pos_q   <= '0;
                        win_q   <= '0;
                    end
                end
                S_FILL, S_SCAN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        win_q <= win_d;
                        if (pos_q != POS_MAX) pos_q <= pos_q + POS_W'(1);
                        if (state_q == S_FILL) begin
                            if (fill_q == FILL_LAST) state_q <= S_SCAN;
                            else fill_q <= fill_q + IW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (cmp && (|hit)) begin
                match_valid_q <= 1'b1;
                match_mask_q  <= hit;
                // A saturated position no longer identifies a window start.
                match_pos_q   <= (pos_q == POS_MAX) ? POS_MAX
                                                    : pos_q - POS_W'(PAT_LEN - 1);
            end

            for (int p = 0; p < NUM_PAT; p++) begin
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (cfg_we && (state_q == S_IDLE) &&
                        (cfg_pat == PW'(p)) && (cfg_idx == IW'(i)))
                        pat_q[p][i] <= cfg_base;
                end
                if (clr_cnt) cnt_q[p] <= '0;
                else if (cmp && hit[p] && (cnt_q[p] != CNT_MAX))
                    cnt_q[p] <= cnt_q[p] + CNT_W'(1);
            end
        end
    end

    assign match_valid = match_valid_q;
    assign match_mask  = match_mask_q;
    assign match_pos   = match_pos_q;
    assign hit_count   = cnt_q;

endmodule

// File: doc/gene_matcher_stream.md
# gene_matcher_stream

Streaming DNA motif matcher, the parametrised successor to the single-pattern gene matcher. It accepts one 2-bit nucleotide per cycle over a valid/ready stream and keeps a sliding window of the last PAT_LEN bases. Each cycle it compares that window against NUM_PAT programmable patterns, with a runtime Hamming-distance tolerance. It reports a match mask, the stream position of each match, and a saturating hit count per pattern. It sits between the chip-level pin wrapper (which deserialises bases) and the readout logic.

## Interface
- PAT_LEN, 8: bases per pattern (≥2).
- NUM_PAT, 2: number of independent patterns (≥1).
- MM_W, 3: width of mismatch threshold.
- POS_W, 16: width of stream position counter.
- CNT_W, 12: width of each per-pattern hit counter.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- cfg_we  in  1  pattern write strobe.
- cfg_pat  in  max(1,clog2(NUM_PAT))  pattern select.
- cfg_idx  in  clog2(PAT_LEN)  base index within pattern (0 = first/oldest base).
- cfg_base  in  2  base code: A=00, C=01, G=10, T=11.
- mm_thresh  in  MM_W  max mismatching bases still counted as a hit; sampled per compare.
- start  in  1  IDLE→FILL pulse.
- stop  in  1  return to IDLE.
- clr_cnt  in  1  zero all hit counters.
- in_valid  in  1  base available.
- in_base  in  2  base code.
- in_ready  out  1  block accepts base.
- busy  out  1  state ≠ IDLE.
- match_valid  out  1  one-cycle pulse, ≥1 pattern hit.
- match_mask  out  NUM_PAT  bit p = pattern p hit.
- match_pos  out  POS_W  stream index of first base of matched window.
- hit_count  out  NUM_PAT*CNT_W  pattern p in bits [p*CNT_W +: CNT_W].

## Operation
- States: IDLE, FILL, SCAN.
  - IDLE: in_ready=0. Pattern writes are honoured.
  - start → FILL, clearing the window fill count and the position counter.
  - FILL: accept bases. After PAT_LEN-1 accepted bases, go to SCAN on the accept of base PAT_LEN-1 (0-based). That base is compared.
  - SCAN: every accepted base is compared.
  - stop from FILL or SCAN → IDLE. Hit counters are retained.
  - start while busy is ignored.
- in_ready = (state is FILL or SCAN) and !stop. Stop has priority over a same-cycle in_valid; that base is not accepted.
- Accept = in_valid & in_ready. On accept: shift in_base into the window, then increment the position counter. The counter saturates at 2^POS_W-1.
- Compare (SCAN, or the final FILL accept):
  - mm_p = count of i where window base (arrival order) ≠ pat[p][i].
  - hit_p = (mm_p ≤ mm_thresh).
- Pattern writes:
  - cfg_we in IDLE writes pat[cfg_pat][cfg_idx].
  - cfg_we while busy is ignored.
  - Out-of-range cfg_pat or cfg_idx is ignored.
  - Patterns reset to all-A (00).
- Registered outputs, updated at the edge after an accepted compare:
  - match_valid = |hit.
  - match_mask = hit.
  - match_pos = index of the accepted base − (PAT_LEN-1). If the accepted base's index is the saturated value, match_pos = 2^POS_W-1.
  - match_mask and match_pos hold their values until the next match_valid.
- hit_count[p] increments by 1 per hit_p. It saturates at 2^CNT_W-1. clr_cnt in the same cycle as a hit: clear wins, result 0.
- Reset values: in_ready=0, busy=0, match_valid=0, match_mask=0, match_pos=0, hit_count=0, state=IDLE, window=0.

## Timing
- Base accepted at edge t → match_valid/mask/pos valid during cycle t+1 (latency 1). hit_count is updated at the same edge.
- Sustained throughput: 1 base/cycle. in_ready is never deasserted by backpressure, only by state or stop.
- No match is reported for the first PAT_LEN-1 bases after start.
- rst mid-stream: immediate asynchronous return to the reset state. Patterns are lost; counters are zeroed.
- stop then start: the window restarts empty, so no match can span the two sessions.
- A gap in in_valid does not age the window; only accepted bases shift it.

## Test plan
Configuration for all scenarios: PAT_LEN=4, NUM_PAT=2.
- Exact match: pat0=ACGT, mm_thresh=0, start, stream A,C,G,T back-to-back → one cycle after T is accepted, match_valid=1, mask=01, pos=0, hit_count[0]=1.
- Tolerance: pat1=AAAA, mm_thresh=1, stream A,C,A,A → mask=10, pos=0. With mm_thresh=0 the same stream gives no match_valid.
- Overlap/multi: pat0=AAAA, pat1=AAAA, mm_thresh=0, stream 6×A → match_valid in 3 consecutive cycles, mask=11, pos=0,1,2, each hit_count=3.
- Control priority:
  - stop asserted in the same cycle as in_valid → base not accepted, busy=0 next cycle.
  - cfg_we while busy → pattern unchanged.
  - clr_cnt coincident with a hit → hit_count=0.
- Saturation/reset:
  - CNT_W=2, 5 hits → hit_count=3.
  - POS_W=3, stream 12 bases of a matching run → match_pos saturates at 7.
  - rst pulse mid-stream → all outputs 0 asynchronously; matching resumes only after start.
